player_motion: RTL and testbench
================================

Name: player_motion

Overview:
Upstream stage of the sprite renderer. Produces the signed player position (sprite_x, sprite_y) that the sprite pixel generator compares against the beam position. It updates the position once per video frame from three push-buttons, with clamped horizontal walking and a jump/gravity state machine. Outputs are held constant between frame updates, so the renderer never sees a position change mid-frame.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
SPRITE_W, 100, sprite width (must match renderer box)
SPRITE_H, 200, sprite height (must match renderer box)
STEP, 4, horizontal pixels moved per frame
JUMP_V, 12, initial upward velocity (px/frame)
GRAVITY, 1, velocity change per frame
MAX_FALL, 12, downward velocity cap
GROUND_Y, SCREEN_H-SPRITE_H (280), resting top-of-sprite y

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse at start of vertical blank
btn_left  in  1  raw button, asynchronous
btn_right  in  1  raw button, asynchronous
btn_jump  in  1  raw button, asynchronous
sprite_x  out  11 signed  sprite left edge
sprite_y  out  11 signed  sprite top edge
airborne  out  1  high in RISING or FALLING
pos_valid  out  1  one-cycle pulse when the position is updated

Behaviour:
- Interface: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Reset values: sprite_x=(SCREEN_W-SPRITE_W)/2=270; sprite_y=GROUND_Y=280; vy=0; state=GROUNDED; airborne=0; pos_valid=0. Synchronizer flops are cleared to 0.
- Buttons: each passes through a 2-flop synchronizer. Only the synchronized level is used, so it must be stable for at least 2 clk cycles before frame_tick. Buttons are level-sensitive and are not edge-detected.
- Update timing: all state changes only on a clk edge where frame_tick=1. New values appear on the next edge with 1-cycle latency, and pos_valid=1 for exactly that cycle. With no tick, all outputs hold. Back-to-back ticks give back-to-back updates.
- Horizontal movement per tick:
  - left only: x-STEP; right only: x+STEP; both or neither: no change.
  - Result is clamped to [0, SCREEN_W-SPRITE_W]=[0,540]. Compute at 12 bits before clamping; no wrap.
  - Horizontal movement is independent of the vertical state.
- Vertical FSM (vy is an unsigned magnitude, at least 6 bits):
  - GROUNDED:
    - jump=1: y_next=y-JUMP_V; vy_next=JUMP_V-GRAVITY; go to RISING.
    - jump=0: y stays at GROUND_Y.
  - RISING:
    - y_next=y-vy; vy_next=vy-GRAVITY.
    - If vy_next<=0: vy_next=0, go to FALLING.
    - If y_next<0: clamp y_next=0, vy_next=0, go to FALLING.
  - FALLING:
    - vy_next=min(vy+GRAVITY, MAX_FALL); y_next=y+vy_next.
    - If y_next>=GROUND_Y: y_next=GROUND_Y, vy_next=0, go to GROUNDED.
  - jump is ignored in RISING and FALLING. With jump held, a new jump starts on the first tick after landing, never on the landing tick itself.
- airborne is a registered output equal to (state!=GROUNDED). It updates together with the position.
- Reset asserted mid-jump immediately forces all reset values, regardless of clk.
- Defaults give a jump of 24 ticks: apex y=202 reached on tick 12; lands at y=280 on tick 24.
- sprite_x and sprite_y are always non-negative. They are declared signed to match the renderer.

Test Plan:
- Release rst_n with no ticks -> sprite_x=270, sprite_y=280, airborne=0, pos_valid=0 stays low.
- btn_right held, 10 frame_ticks -> sprite_x=310 and pos_valid pulses 10 times. Holding for 100 ticks gives sprite_x=540 (clamp), and it stays 540.
- btn_left and btn_right both held, 5 ticks -> sprite_x unchanged at 270. btn_left alone for 80 ticks -> sprite_x=0, never negative.
- btn_jump pulsed for one tick, then released -> sprite_y sequence 268,257,247,...,202 (tick 12), then 203,205,... down to 280 at tick 24. airborne=1 for ticks 1-23 and 0 after tick 24.
- btn_jump held continuously -> lands at 280 on tick 24, next jump starts on tick 25 (y=268). Right held throughout -> x increases by 4 every tick while airborne.
- Assert rst_n low mid-jump, off a clk edge -> outputs return to 270/280/airborne=0 at once. After release, no change until the next frame_tick.

Source files
------------

// File: rtl/player_motion.sv
// Purpose: per-frame player sprite position with clamped walking and jump/gravity FSM.
// Latency: position updates one clk after a frame_tick edge; pos_valid pulses for that cycle.
// Backpressure: none; free-running, the renderer samples the held position at any time.
module player_motion #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SPRITE_W = 100,
  parameter int SPRITE_H = 200,
  parameter int STEP     = 4,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_jump,
  output logic signed [10:0] sprite_x,
  output logic signed [10:0] sprite_y,
  output logic               airborne,
  output logic               pos_valid
);

  localparam int X_MAX    = SCREEN_W - SPRITE_W;
  localparam int X_RST    = X_MAX / 2;
  localparam int GROUND_Y = SCREEN_H - SPRITE_H;

  // All position arithmetic is done at 12 bits signed so under/overflow is
  // visible before clamping instead of wrapping.
  localparam logic signed [11:0] C_X_MAX    = 12'(X_MAX);
  localparam logic signed [11:0] C_STEP     = 12'(STEP);
  localparam logic signed [11:0] C_JUMP_V   = 12'(JUMP_V);
  localparam logic signed [11:0] C_GRAVITY  = 12'(GRAVITY);
  localparam logic signed [11:0] C_MAX_FALL = 12'(MAX_FALL);
  localparam logic signed [11:0] C_GROUND_Y = 12'(GROUND_Y);
  localparam logic signed [11:0] C_ZERO     = 12'sd0;

  typedef enum logic [1:0] {
    ST_GROUNDED = 2'd0,
    ST_RISING   = 2'd1,
    ST_FALLING  = 2'd2
  } state_t;

  // Button synchronizers: bit 0 = left, bit 1 = right, bit 2 = jump.
  logic [2:0] r_btn_meta;
  logic [2:0] r_btn_sync;

  logic signed [10:0] r_x;
  logic signed [10:0] r_y;
  logic [5:0]         r_vy;
  state_t             r_state;
  logic               r_airborne;
  logic               r_pos_valid;

  logic               w_left;
  logic               w_right;
  logic               w_jump;
  logic signed [11:0] w_x_wide;
  logic signed [10:0] w_x_next;
  logic signed [11:0] w_y_wide;
  logic signed [11:0] w_vy_wide;
  state_t             w_state_next;

  // Two-flop synchronizer for the asynchronous push-buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_meta <= 3'b000;
      r_btn_sync <= 3'b000;
    end else begin
      r_btn_meta <= {btn_jump, btn_right, btn_left};
      r_btn_sync <= r_btn_meta;
    end
  end

  assign w_left  = r_btn_sync[0];
  assign w_right = r_btn_sync[1];
  assign w_jump  = r_btn_sync[2];

  // Horizontal step with clamping to the visible range; opposing buttons cancel.
  always_comb begin
    w_x_wide = {r_x[10], r_x};
    if (w_left && !w_right) begin
      w_x_wide = w_x_wide - C_STEP;
    end else if (w_right && !w_left) begin
      w_x_wide = w_x_wide + C_STEP;
    end
    if (w_x_wide < C_ZERO) begin
      w_x_wide = C_ZERO;
    end else if (w_x_wide > C_X_MAX) begin
      w_x_wide = C_X_MAX;
    end
    w_x_next = w_x_wide[10:0];
  end

  // Vertical next-state: jump launch, decelerating rise, capped fall, landing.
  always_comb begin
    w_state_next = r_state;
    w_y_wide     = {r_y[10], r_y};
    w_vy_wide    = {6'b000000, r_vy};
    case (r_state)
      ST_GROUNDED: begin
        if (w_jump) begin
          w_y_wide     = w_y_wide - C_JUMP_V;
          w_vy_wide    = C_JUMP_V - C_GRAVITY;
          w_state_next = ST_RISING;
        end else begin
          w_y_wide  = C_GROUND_Y;
          w_vy_wide = C_ZERO;
        end
      end
      ST_RISING: begin
        w_y_wide  = w_y_wide - w_vy_wide;
        w_vy_wide = w_vy_wide - C_GRAVITY;
        if (w_vy_wide <= C_ZERO) begin
          w_vy_wide    = C_ZERO;
          w_state_next = ST_FALLING;
        end
        // Hitting the top of the screen kills the remaining upward speed.
        if (w_y_wide < C_ZERO) begin
          w_y_wide     = C_ZERO;
          w_vy_wide    = C_ZERO;
          w_state_next = ST_FALLING;
        end
      end
      ST_FALLING: begin
        w_vy_wide = w_vy_wide + C_GRAVITY;
        if (w_vy_wide > C_MAX_FALL) begin
          w_vy_wide = C_MAX_FALL;
        end
        w_y_wide = w_y_wide + w_vy_wide;
        // Landing tick always ends GROUNDED; a held jump relaunches next tick.
        if (w_y_wide >= C_GROUND_Y) begin
          w_y_wide     = C_GROUND_Y;
          w_vy_wide    = C_ZERO;
          w_state_next = ST_GROUNDED;
        end
      end
      default: begin
        w_y_wide     = C_GROUND_Y;
        w_vy_wide    = C_ZERO;
        w_state_next = ST_GROUNDED;
      end
    endcase
  end

  // State register: everything advances only on frame_tick so outputs hold mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= 11'(X_RST);
      r_y         <= 11'(GROUND_Y);
      r_vy        <= 6'd0;
      r_state     <= ST_GROUNDED;
      r_airborne  <= 1'b0;
      r_pos_valid <= 1'b0;
    end else begin
      r_pos_valid <= frame_tick;
      if (frame_tick) begin
        r_x        <= w_x_next;
        r_y        <= w_y_wide[10:0];
        r_vy       <= w_vy_wide[5:0];
        r_state    <= w_state_next;
        r_airborne <= (w_state_next != ST_GROUNDED);
      end
    end
  end

  assign sprite_x  = r_x;
  assign sprite_y  = r_y;
  assign airborne  = r_airborne;
  assign pos_valid = r_pos_valid;

endmodule

// File: tb/tb_player_motion.sv
// Purpose: directed checks of player_motion walking, clamping, jump arc, reset and tick timing.
// Latency: checks sample on the falling edge after each tick edge.
// Backpressure: none; the bench drives frame_tick directly.
module tb_player_motion;

  logic               clk;
  logic               rst_n;
  logic               frame_tick;
  logic               btn_left;
  logic               btn_right;
  logic               btn_jump;
  logic signed [10:0] sprite_x;
  logic signed [10:0] sprite_y;
  logic               airborne;
  logic               pos_valid;

  int n_cmp = 0;
  int n_err = 0;
  int pv_total = 0;
  int pv_base;
  bit neg_seen = 1'b0;

  // Hand-computed jump arc for default parameters, tick 1..24.
  int exp_y [24] = '{268, 257, 247, 238, 230, 223, 217, 212, 208, 205, 203, 202,
                     203, 205, 208, 212, 217, 223, 230, 238, 247, 257, 268, 280};

  player_motion dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .airborne   (airborne),
    .pos_valid  (pos_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counter and sign monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (pos_valid) pv_total = pv_total + 1;
    if (sprite_x < 0 || sprite_y < 0) neg_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
    btn_jump   = 1'b0;
    #23 rst_n  = 1'b1;
    idle(5);
    #1;
    check_eq("rst_x", int'(sprite_x), 270);
    check_eq("rst_y", int'(sprite_y), 280);
    check_eq("rst_airborne", int'(airborne), 0);
    check_eq("rst_pv_count", pv_total, 0);

    // Walk right, then into the right clamp.
    btn_right = 1'b1;
    idle(3);
    pv_base = pv_total;
    repeat (10) do_tick();
    #1;
    check_eq("right10_x", int'(sprite_x), 310);
    check_eq("right10_pv", pv_total - pv_base, 10);
    check_eq("right10_y", int'(sprite_y), 280);
    repeat (100) do_tick();
    check_eq("right_clamp_x", int'(sprite_x), 540);
    do_tick();
    check_eq("right_clamp_hold_x", int'(sprite_x), 540);

    // Both buttons cancel; left alone walks into the left clamp.
    btn_right = 1'b0;
    do_reset();
    btn_left  = 1'b1;
    btn_right = 1'b1;
    idle(3);
    repeat (5) do_tick();
    check_eq("both_x", int'(sprite_x), 270);
    btn_right = 1'b0;
    idle(3);
    repeat (80) do_tick();
    check_eq("left_clamp_x", int'(sprite_x), 0);
    check_eq("never_negative", int'(neg_seen), 0);
    btn_left = 1'b0;

    // Single jump pulse, full 24-tick arc.
    do_reset();
    btn_jump = 1'b1;
    idle(3);
    do_tick();
    btn_jump = 1'b0;
    check_eq("jump_t1_y", int'(sprite_y), exp_y[0]);
    check_eq("jump_t1_air", int'(airborne), 1);
    idle(3);
    for (int t = 2; t <= 24; t++) begin
      do_tick();
      check_eq($sformatf("jump_t%0d_y", t), int'(sprite_y), exp_y[t-1]);
      check_eq($sformatf("jump_t%0d_air", t), int'(airborne), (t < 24) ? 1 : 0);
    end
    do_tick();
    check_eq("jump_t25_y", int'(sprite_y), 280);
    check_eq("jump_t25_air", int'(airborne), 0);
    check_eq("jump_x", int'(sprite_x), 270);

    // Held jump with right held: relaunch on tick 25, x walks while airborne.
    do_reset();
    btn_jump  = 1'b1;
    btn_right = 1'b1;
    idle(3);
    for (int t = 1; t <= 24; t++) begin
      do_tick();
      check_eq($sformatf("hold_t%0d_y", t), int'(sprite_y), exp_y[t-1]);
      check_eq($sformatf("hold_t%0d_x", t), int'(sprite_x), 270 + 4 * t);
    end
    check_eq("hold_land_air", int'(airborne), 0);
    do_tick();
    check_eq("hold_t25_y", int'(sprite_y), 268);
    check_eq("hold_t25_air", int'(airborne), 1);
    check_eq("hold_t25_x", int'(sprite_x), 370);

    // Asynchronous reset mid-jump, then quiet until the next tick.
    btn_jump = 1'b0;
    do_reset();
    btn_jump = 1'b1;
    idle(3);
    repeat (5) do_tick();
    btn_jump = 1'b0;
    check_eq("midjump_y", int'(sprite_y), 230);
    check_eq("midjump_x", int'(sprite_x), 290);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_x", int'(sprite_x), 270);
    check_eq("async_rst_y", int'(sprite_y), 280);
    check_eq("async_rst_air", int'(airborne), 0);
    #1 rst_n = 1'b1;
    pv_base = pv_total;
    idle(5);
    #1;
    check_eq("post_rst_x", int'(sprite_x), 270);
    check_eq("post_rst_y", int'(sprite_y), 280);
    check_eq("post_rst_pv", pv_total - pv_base, 0);
    do_tick();
    check_eq("post_rst_tick_x", int'(sprite_x), 274);

    // Back-to-back ticks give back-to-back updates.
    idle(1);
    pv_base = pv_total;
    frame_tick = 1'b1;
    idle(3);
    frame_tick = 1'b0;
    idle(2);
    #1;
    check_eq("b2b_x", int'(sprite_x), 286);
    check_eq("b2b_pv", pv_total - pv_base, 3);
    check_eq("final_never_negative", int'(neg_seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
